// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: multi-lane pipeline register with lane kill, bubble zeroing, stall error flag, perf counters
// Ports: clk/rst (async active-high); stall_up_i/stall_dn_i/flush_i/flush_exc_i/kill_mask_i drive the
// stage action; valid_i/data_i/shared_i are captured into valid_o/data_o/shared_o; empty_o = no valid lane;
// bubble_cnt_o/hold_cnt_o saturating counters cleared by cnt_clr_i; err_o sticky illegal-stall flag.
module pipe_stage_reg #(
  parameter int LANES          = 2,
  parameter int LANE_W         = 112,
  parameter int SHARED_W       = 140,
  parameter int ZERO_ON_BUBBLE = 1,
  parameter int CNT_W          = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_up_i,
  input  logic                      stall_dn_i,
  input  logic                      flush_i,
  input  logic                      flush_exc_i,
  input  logic [LANES-1:0]          kill_mask_i,
  input  logic [LANES-1:0]          valid_i,
  input  logic [LANES*LANE_W-1:0]   data_i,
  input  logic [SHARED_W-1:0]       shared_i,
  input  logic                      cnt_clr_i,
  output logic [LANES-1:0]          valid_o,
  output logic [LANES*LANE_W-1:0]   data_o,
  output logic [SHARED_W-1:0]       shared_o,
  output logic                      empty_o,
  output logic [CNT_W-1:0]          bubble_cnt_o,
  output logic [CNT_W-1:0]          hold_cnt_o,
  output logic                      err_o
);
  localparam bit ZOB = ZERO_ON_BUBBLE != 0;
  localparam logic [CNT_W-1:0] CMAX = '1;
  logic exc, hold, bub;
  logic [LANES-1:0] kill, nv;
  logic [LANES*LANE_W-1:0] nd;
  assign exc  = flush_i & flush_exc_i;
  assign hold = ~exc & stall_dn_i;
  assign bub  = ~exc & stall_up_i & ~stall_dn_i;
  // branch flush squashes only the masked lanes; exception flush is handled separately
  assign kill = {LANES{flush_i & ~flush_exc_i}} & kill_mask_i;
  assign nv   = valid_i & ~kill;
  assign empty_o = ~|valid_o;
  always_comb begin
    nd = data_i;
    for (int k = 0; k < LANES; k++)
      nd[k*LANE_W +: LANE_W] = (ZOB && kill[k]) ? '0 : data_i[k*LANE_W +: LANE_W];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o  <= '0;
      data_o   <= '0;
      shared_o <= '0;
    end else if (exc) begin
      valid_o  <= '0;
      data_o   <= '0;
      shared_o <= '0;
    end else if (!stall_dn_i) begin
      if (stall_up_i) begin
        valid_o <= '0;
        if (ZOB) begin
          data_o   <= '0;
          shared_o <= '0;
        end
      end else begin
        valid_o  <= nv;
        data_o   <= nd;
        shared_o <= (ZOB && ~|nv) ? '0 : shared_i;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_o <= '0;
      hold_cnt_o   <= '0;
    end else if (cnt_clr_i) begin
      bubble_cnt_o <= '0;
      hold_cnt_o   <= '0;
    end else begin
      if (bub && bubble_cnt_o != CMAX) bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
      if (hold && hold_cnt_o != CMAX) hold_cnt_o <= hold_cnt_o + CNT_W'(1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_o <= 1'b0;
    else if (stall_dn_i && !stall_up_i) err_o <= 1'b1;
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: random + directed check of pipe_stage_reg in both bubble modes against a behavioural model
module tb_pipe_stage_reg;
  localparam int L = 2, LW = 16, SW = 20, CW = 4, CMAX = 15;
  logic clk = 1'b0, rst = 1'b1;
  logic stall_up = 0, stall_dn = 0, flush = 0, flush_exc = 0, cnt_clr = 0;
  logic [L-1:0] kill_mask = '0, valid_in = '0;
  logic [L*LW-1:0] data_in = '0;
  logic [SW-1:0] shared_in = '0;
  logic [L-1:0] vo [2];
  logic [L*LW-1:0] dout [2];
  logic [SW-1:0] so [2];
  logic eo [2], erro [2];
  logic [CW-1:0] bco [2], hco [2];
  int checks = 0, failures = 0;
  bit cmp_en = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipe_stage_reg #(.LANES(L), .LANE_W(LW), .SHARED_W(SW), .ZERO_ON_BUBBLE(1 - g), .CNT_W(CW)) u (
      .clk(clk), .rst(rst), .stall_up_i(stall_up), .stall_dn_i(stall_dn), .flush_i(flush),
      .flush_exc_i(flush_exc), .kill_mask_i(kill_mask), .valid_i(valid_in), .data_i(data_in),
      .shared_i(shared_in), .cnt_clr_i(cnt_clr), .valid_o(vo[g]), .data_o(dout[g]), .shared_o(so[g]),
      .empty_o(eo[g]), .bubble_cnt_o(bco[g]), .hold_cnt_o(hco[g]), .err_o(erro[g]));
  end
  // model: index 0 zeroes on bubble, index 1 keeps payload
  logic [L-1:0] mv [2];
  logic [LW-1:0] md [2][L];
  logic [SW-1:0] ms [2];
  int mb [2], mh [2];
  logic me [2];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mv[i] <= '0; ms[i] <= '0; mb[i] <= 0; mh[i] <= 0; me[i] <= 1'b0;
        for (int k = 0; k < L; k++) md[i][k] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        automatic bit zob = (i == 0);
        automatic bit exc = flush && flush_exc;
        automatic bit any = 0;
        if (exc) begin
          mv[i] <= '0; ms[i] <= '0;
          for (int k = 0; k < L; k++) md[i][k] <= '0;
        end else if (stall_dn) begin
        end else if (stall_up) begin
          mv[i] <= '0;
          if (zob) begin
            ms[i] <= '0;
            for (int k = 0; k < L; k++) md[i][k] <= '0;
          end
        end else begin
          for (int k = 0; k < L; k++) begin
            automatic bit killed = flush && kill_mask[k];
            automatic bit nv = valid_in[k] && !killed;
            mv[i][k] <= nv;
            md[i][k] <= (killed && zob) ? '0 : data_in[k*LW +: LW];
            any |= nv;
          end
          ms[i] <= (zob && !any) ? '0 : shared_in;
        end
        if (cnt_clr) begin
          mb[i] <= 0; mh[i] <= 0;
        end else begin
          if (!exc && stall_dn) mh[i] <= (mh[i] < CMAX) ? mh[i] + 1 : CMAX;
          if (!exc && stall_up && !stall_dn) mb[i] <= (mb[i] < CMAX) ? mb[i] + 1 : CMAX;
        end
        if (stall_dn && !stall_up) me[i] <= 1'b1;
      end
    end
  end
  function automatic logic [L*LW-1:0] pack(int i);
    logic [L*LW-1:0] r;
    for (int k = 0; k < L; k++) r[k*LW +: LW] = md[i][k];
    return r;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (cmp_en) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("m%0d.valid", i), 64'(vo[i]), 64'(mv[i]));
      chk($sformatf("m%0d.data", i), 64'(dout[i]), 64'(pack(i)));
      chk($sformatf("m%0d.shared", i), 64'(so[i]), 64'(ms[i]));
      chk($sformatf("m%0d.empty", i), 64'(eo[i]), 64'(mv[i] == '0));
      chk($sformatf("m%0d.bubble", i), 64'(bco[i]), 64'(mb[i]));
      chk($sformatf("m%0d.hold", i), 64'(hco[i]), 64'(mh[i]));
      chk($sformatf("m%0d.err", i), 64'(erro[i]), 64'(me[i]));
    end
  end
  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  localparam logic [LW-1:0] A = 16'hAAAA, B = 16'hBBBB;
  initial begin
    step(2);
    rst = 1'b0;
    cmp_en = 1;
    chk("rst.valid", 64'(vo[0]), 64'h0);
    chk("rst.err", 64'(erro[0]), 64'h0);
    valid_in = 2'b11; data_in = {A, B}; shared_in = 20'h12345;
    flush = 1; flush_exc = 0; kill_mask = 2'b10;
    step();
    chk("kill.valid", 64'(vo[0]), 64'h1);
    chk("kill.data_z", 64'(dout[0]), 64'h0000BBBB);
    chk("kill.data_k", 64'(dout[1]), 64'hAAAABBBB);
    flush = 0;
    step();
    stall_up = 1; stall_dn = 1; flush = 1; kill_mask = 2'b11;
    step(3);
    chk("hold.valid", 64'(vo[0]), 64'h3);
    chk("hold.data", 64'(dout[0]), 64'hAAAABBBB);
    chk("hold.cnt", 64'(hco[0]), 64'd3);
    flush_exc = 1;
    step();
    chk("exc.valid", 64'(vo[1]), 64'h0);
    chk("exc.data", 64'(dout[1]), 64'h0);
    chk("exc.shared", 64'(so[1]), 64'h0);
    chk("exc.hold", 64'(hco[0]), 64'd3);
    flush = 0; flush_exc = 0; stall_up = 0; stall_dn = 0;
    step();
    stall_up = 1;
    step();
    chk("bub.data_z", 64'(dout[0]), 64'h0);
    chk("bub.valid_k", 64'(vo[1]), 64'h0);
    chk("bub.data_k", 64'(dout[1]), 64'hAAAABBBB);
    chk("bub.shared_k", 64'(so[1]), 64'h12345);
    chk("bub.cnt", 64'(bco[1]), 64'd1);
    step(19);
    chk("sat.cnt", 64'(bco[0]), 64'd15);
    cnt_clr = 1;
    step();
    chk("clr.bub", 64'(bco[0]), 64'd0);
    chk("clr.hold", 64'(hco[0]), 64'd0);
    cnt_clr = 0; stall_up = 0; stall_dn = 1;
    step();
    chk("err.set", 64'(erro[0]), 64'd1);
    stall_dn = 0;
    step(3);
    chk("err.sticky", 64'(erro[1]), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst.valid", 64'(vo[0]), 64'h0);
    chk("arst.data", 64'(dout[1]), 64'h0);
    chk("arst.empty", 64'(eo[0]), 64'd1);
    chk("arst.err", 64'(erro[0]), 64'd0);
    step();
    rst = 1'b0;
    repeat (600) begin
      stall_up = ($urandom_range(9) < 3);
      stall_dn = ($urandom_range(9) < 2);
      flush = ($urandom_range(3) == 0);
      flush_exc = flush && $urandom_range(1);
      if (flush_exc && stall_dn) stall_up = 1;
      kill_mask = L'($urandom);
      valid_in = L'($urandom);
      data_in = $urandom;
      shared_in = SW'($urandom);
      cnt_clr = ($urandom_range(39) == 0);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised multi-lane pipeline stage register, successor to the fixed dual-issue EX/MEM register. It carries `LANES` issue slots of `LANE_W` payload each plus one shared sideband word, for example HI/LO/whilo/aluop. Beyond plain capture, it supports:
- per-lane valid bits and selective lane kill on branch flush;
- a configurable bubble-zeroing mode;
- a sticky stall-protocol error flag;
- saturating bubble/hold performance counters.

It sits between any two pipeline stages (EX→MEM, MEM→WB) and is driven by the core's stall/flush controller.

## Interface
Parameters:
- `LANES`, 2, number of issue lanes (≥1)
- `LANE_W`, 112, payload bits per lane (addr, waddr, we, wdata, corr pack, delayslot…)
- `SHARED_W`, 140, shared sideband bits (branch info, hi, lo, whilo, aluop, mem_addr, reg2)
- `ZERO_ON_BUBBLE`, 1, 1 = zero payload of invalid lanes on bubble/kill; 0 = clear valid only, payload untouched
- `CNT_W`, 16, width of performance counters

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `stall_up_i`  in  1  upstream stage stalled (stall[n])
- `stall_dn_i`  in  1  this stage's consumer stalled (stall[n+1])
- `flush_i`  in  1  flush request
- `flush_exc_i`  in  1  flush cause: 1 = exception, 0 = branch
- `kill_mask_i`  in  LANES  lanes to squash on branch flush
- `valid_i`  in  LANES  incoming lane valids
- `data_i`  in  LANES*LANE_W  lane payloads, lane k at [k*LANE_W +: LANE_W]
- `shared_i`  in  SHARED_W  shared sideband
- `cnt_clr_i`  in  1  synchronous clear of both counters
- `valid_o`  out  LANES  registered lane valids
- `data_o`  out  LANES*LANE_W  registered payloads
- `shared_o`  out  SHARED_W  registered sideband
- `empty_o`  out  1  ~|valid_o, combinational from registers only
- `bubble_cnt_o`  out  CNT_W  bubbles inserted, saturating
- `hold_cnt_o`  out  CNT_W  hold cycles, saturating
- `err_o`  out  1  sticky: stall_dn_i=1 while stall_up_i=0 seen

## Operation
Every edge, the stage takes exactly one action, evaluated in this priority order:
1. **Reset** (`rst`=1, async): all outputs 0.
2. **Exception flush** (`flush_i`=1, `flush_exc_i`=1):
   - `valid_o`, `data_o` and `shared_o` are set to 0, regardless of stall inputs or `ZERO_ON_BUBBLE`.
   - Counters are not incremented.
3. **Hold** (`stall_dn_i`=1):
   - All data/valid registers keep their value.
   - A branch flush in the same cycle is ignored; upstream re-presents the instruction.
   - `hold_cnt_o` +1.
4. **Bubble** (`stall_up_i`=1, `stall_dn_i`=0):
   - `valid_o` ← 0.
   - If `ZERO_ON_BUBBLE`=1: `data_o` ← 0 and `shared_o` ← 0. Otherwise payloads are kept.
   - `bubble_cnt_o` +1.
5. **Load** (`stall_up_i`=0, `stall_dn_i`=0):
   - Per lane k: `valid_o[k]` ← `valid_i[k]` & ~(`flush_i` & ~`flush_exc_i` & `kill_mask_i[k]`).
   - `data_o` lane k ← `data_i` lane k, or 0 if the lane is killed and `ZERO_ON_BUBBLE`=1.
   - `shared_o` ← `shared_i`, or 0 if all lanes end invalid and `ZERO_ON_BUBBLE`=1.

Additional rules:
- **Illegal combo** (`stall_dn_i`=1, `stall_up_i`=0): handled as Hold, and sets `err_o` on that edge. `err_o` is cleared only by `rst`.
- **Counters:**
  - Precedence: `rst` > `cnt_clr_i` > increment. When `cnt_clr_i`=1 the counter becomes 0 and that cycle's event is not counted.
  - Saturate at 2^CNT_W−1; no wrap.
  - Exception flush does not clear the counters.
- Valid bits are independent per lane: lane 1 may be valid with lane 0 invalid.

## Timing
- Latency is 1 cycle from inputs to outputs; all outputs are registered except `empty_o` (decoded from `valid_o` only, with no combinational input→output path).
- An asynchronous `rst` assertion takes effect immediately, mid-cycle. Deassertion is treated as synchronous to `clk` by the system reset synchroniser.
- Hold is sustainable for any number of cycles with no data loss. `hold_cnt_o` keeps counting until it saturates.
- Back-to-back exception flushes each zero the stage. An exception flush on the edge where stalls release leaves the stage empty; it does not load.

## Test plan
- **Reset:** assert `rst` mid-cycle with `valid_o`=2'b11 → all outputs 0 before the next edge; `empty_o`=1.
- **Load with branch kill** (LANES=2, ZERO_ON_BUBBLE=1): `valid_i`=2'b11, `data_i`={A,B}, `flush_i`=1, `flush_exc_i`=0, `kill_mask_i`=2'b10 → next cycle `valid_o`=2'b01, lane0=B, lane1=0.
- **Hold vs branch flush:** stage holds {A,B}. Drive `stall_up_i`=`stall_dn_i`=1 with a branch flush for 3 cycles → outputs unchanged, `hold_cnt_o`=3.
- **Exception flush during hold:** stage holds {A,B} and `stall_dn_i`=1; assert `flush_i`=1, `flush_exc_i`=1 → next cycle `valid_o`=0, `data_o`=0, `shared_o`=0, `hold_cnt_o` unchanged.
- **Bubble modes:** `stall_up_i`=1, `stall_dn_i`=0 → with ZERO_ON_BUBBLE=1, payload becomes 0; with ZERO_ON_BUBBLE=0, `valid_o`=0 and payload is retained; `bubble_cnt_o` +1 per cycle in both.
- **Saturation and error** (CNT_W=4): 20 bubble cycles → `bubble_cnt_o`=15. Assert `cnt_clr_i` → 0. Drive `stall_dn_i`=1 with `stall_up_i`=0 for one cycle → `err_o`=1 and stays 1 until `rst`.
